// File: rtl/stage5_msg_pack_pkg.sv
// Shared constants for the stage-5 message packer: field widths, type codes, fill value,
// field bit-position helpers and the serializer state encoding.
package stage5_msg_pack_pkg;

    localparam int MAX_MESSAGE_BITS          = 256;
    localparam int MSG_OUT_WIDTH             = 64;
    localparam int MESSAGE_MUX_CONTROL_WIDTH = 4;
    localparam int FIELD_OP2_BITS            = 32;

    localparam logic [3:0]  MESSAGE_MUX_Q = 4'h1;
    localparam logic [31:0] DEFAUT_INFOR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } msg_state_e;

    // Field positions counted from the message MSB: type, OP1, OP2 slot, then payload.
    function automatic int q_op1_b(input int msg_bits, input int type_bits);
        return msg_bits - 1 - type_bits;
    endfunction

    function automatic int q_op2_b(input int msg_bits, input int type_bits, input int op_bits);
        return msg_bits - 1 - type_bits - op_bits;
    endfunction

    function automatic int q_op2_e(input int msg_bits, input int type_bits, input int op_bits);
        return msg_bits - type_bits - 2 * op_bits;
    endfunction

endpackage

// File: rtl/stage5_msg_assemble.sv
// Combinational field-to-word packer; the OP2 slot carries in_op2 only for q-type messages.
module stage5_msg_assemble
    import stage5_msg_pack_pkg::*;
#(
    parameter int                   MSG_BITS      = MAX_MESSAGE_BITS,
    parameter int                   TYPE_BITS     = MESSAGE_MUX_CONTROL_WIDTH,
    parameter int                   OP_BITS       = FIELD_OP2_BITS,
    parameter logic [TYPE_BITS-1:0] TYPE_Q        = MESSAGE_MUX_Q,
    parameter logic [OP_BITS-1:0]   DEFAULT_INFOR = DEFAUT_INFOR
) (
    input  logic [TYPE_BITS-1:0]                   in_type,
    input  logic [OP_BITS-1:0]                     in_op1,
    input  logic [OP_BITS-1:0]                     in_op2,
    input  logic [MSG_BITS-TYPE_BITS-2*OP_BITS-1:0] in_payload,
    output logic [MSG_BITS-1:0]                    msg_word
);

    localparam int OP1_B = q_op1_b(MSG_BITS, TYPE_BITS);
    localparam int OP2_B = q_op2_b(MSG_BITS, TYPE_BITS, OP_BITS);
    localparam int OP2_E = q_op2_e(MSG_BITS, TYPE_BITS, OP_BITS);

    logic [OP_BITS-1:0] op2_slot;

    always_comb begin
        op2_slot = (in_type == TYPE_Q) ? in_op2 : DEFAULT_INFOR;
        msg_word                           = '0;
        msg_word[MSG_BITS-1 -: TYPE_BITS]  = in_type;
        msg_word[OP1_B -: OP_BITS]         = in_op1;
        msg_word[OP2_B:OP2_E]              = op2_slot;
        msg_word[OP2_E-1:0]                = in_payload;
    end

endmodule

// File: rtl/stage5_msg_pack.sv
// Stage-5 message packer: assembles a message word and streams it MSB-first as OUT_WIDTH beats.
// Define STAGE5_MSG_CHECKSUM_EN to append an XOR checksum beat after the data beats.
module stage5_msg_pack
    import stage5_msg_pack_pkg::*;
#(
    parameter int                   MSG_BITS      = MAX_MESSAGE_BITS,
    parameter int                   OUT_WIDTH     = MSG_OUT_WIDTH,
    parameter int                   TYPE_BITS     = MESSAGE_MUX_CONTROL_WIDTH,
    parameter int                   OP_BITS       = FIELD_OP2_BITS,
    parameter logic [TYPE_BITS-1:0] TYPE_Q        = MESSAGE_MUX_Q,
    parameter logic [OP_BITS-1:0]   DEFAULT_INFOR = DEFAUT_INFOR
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    message_en,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [TYPE_BITS-1:0]                    in_type,
    input  logic [OP_BITS-1:0]                      in_op1,
    input  logic [OP_BITS-1:0]                      in_op2,
    input  logic [MSG_BITS-TYPE_BITS-2*OP_BITS-1:0] in_payload,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [OUT_WIDTH-1:0]                    out_data,
    output logic                                    out_first,
    output logic                                    out_last
);

    localparam int NBEATS = MSG_BITS / OUT_WIDTH;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
`ifdef STAGE5_MSG_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic [MSG_BITS-1:0] msg_word;

    msg_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MSG_BITS-1:0] msg_q, msg_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                out_first_q, out_first_d;
    logic                out_last_q, out_last_d;
`ifdef STAGE5_MSG_CHECKSUM_EN
    logic [OUT_WIDTH-1:0] csum_q, csum_d;
`endif

    logic accept;
    logic beat_hs;

    stage5_msg_assemble #(
        .MSG_BITS      (MSG_BITS),
        .TYPE_BITS     (TYPE_BITS),
        .OP_BITS       (OP_BITS),
        .TYPE_Q        (TYPE_Q),
        .DEFAULT_INFOR (DEFAULT_INFOR)
    ) u_assemble (
        .in_type    (in_type),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_payload (in_payload),
        .msg_word   (msg_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_d       = msg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
`ifdef STAGE5_MSG_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        accept  = in_valid && in_ready_q;
        beat_hs = out_valid_q && out_ready;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_d = message_en;
                if (accept) begin
                    state_d     = ST_SEND;
                    cnt_d       = '0;
                    msg_d       = msg_word;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = msg_word[MSG_BITS-1 -: OUT_WIDTH];
                    out_first_d = 1'b1;
                    out_last_d  = !CSUM_EN && (NBEATS == 1);
`ifdef STAGE5_MSG_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            ST_SEND: begin
                if (beat_hs) begin
                    if (int'(cnt_q) + 1 == NBEATS) begin
`ifdef STAGE5_MSG_CHECKSUM_EN
                        state_d     = ST_CSUM;
                        out_data_d  = csum_q ^ out_data_q;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b1;
`else
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = message_en;
`endif
                    end else begin
                        // msg_q shifts so the next beat is always its top slice
                        cnt_d       = cnt_q + 1'b1;
                        msg_d       = msg_q << OUT_WIDTH;
                        out_data_d  = msg_q[MSG_BITS-OUT_WIDTH-1 -: OUT_WIDTH];
                        out_first_d = 1'b0;
                        out_last_d  = !CSUM_EN && (int'(cnt_q) + 2 == NBEATS);
`ifdef STAGE5_MSG_CHECKSUM_EN
                        csum_d      = csum_q ^ out_data_q;
`endif
                    end
                end
            end
`ifdef STAGE5_MSG_CHECKSUM_EN
            ST_CSUM: begin
                if (beat_hs) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b0;
                    in_ready_d  = message_en;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            msg_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef STAGE5_MSG_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            msg_q       <= msg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
`ifdef STAGE5_MSG_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stage5_msg_pack.sv
// Self-checking bench for stage5_msg_pack: message-level beat model checked every cycle,
// plus hand-computed beat literals. Honours STAGE5_MSG_CHECKSUM_EN like the design.
module tb_stage5_msg_pack;

    localparam int NB = 4;
`ifdef STAGE5_MSG_CHECKSUM_EN
    localparam int NT = NB + 1;
`else
    localparam int NT = NB;
`endif

    logic         clk;
    logic         rst_n;
    logic         message_en;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_type;
    logic [31:0]  in_op1;
    logic [31:0]  in_op2;
    logic [187:0] in_payload;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_first;
    logic         out_last;

    stage5_msg_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .message_en (message_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        f;
        logic        l;
    } beat_t;

    beat_t       exp_beats[$];
    logic [63:0] cap[$];
    logic        exp_ready = 1'b0;
    int          acc_total = 0;
    int          dut_acc = 0;
    int          stall_total = 0;
    int          vectors = 0;
    int          errors = 0;

    // Message word straight from the field layout: type | OP1 | OP2-or-fill | payload.
    function automatic logic [255:0] build_word(input logic [3:0] t, input logic [31:0] a,
                                                input logic [31:0] b, input logic [187:0] p);
        logic [31:0] slot;
        slot = (t == 4'h1) ? b : 32'h0;
        return {t, a, slot, p};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model and DUT-side observation, advanced on each rising edge.
    always @(posedge clk) begin
        logic [255:0] w;
        logic [63:0]  cs;
        beat_t        bt;
        logic         acc;
        if (!rst_n) begin
            exp_beats.delete();
            exp_ready = 1'b0;
        end else begin
            if (out_valid && out_ready) cap.push_back(out_data);
            if (out_valid && !out_ready) stall_total++;
            if (in_valid && in_ready) dut_acc++;
            acc = in_valid && exp_ready;
            if (exp_beats.size() > 0 && out_ready) void'(exp_beats.pop_front());
            if (acc) begin
                w  = build_word(in_type, in_op1, in_op2, in_payload);
                cs = '0;
                for (int i = 0; i < NB; i++) begin
                    bt.d = w[255 - 64*i -: 64];
                    bt.f = (i == 0);
                    bt.l = (i == NT - 1);
                    exp_beats.push_back(bt);
                    cs ^= bt.d;
                end
`ifdef STAGE5_MSG_CHECKSUM_EN
                bt.d = cs;
                bt.f = 1'b0;
                bt.l = 1'b1;
                exp_beats.push_back(bt);
`endif
                acc_total++;
                $display("msg %0d accepted: type=%h op1=%h op2=%h", acc_total, in_type, in_op1, in_op2);
            end
            exp_ready = (exp_beats.size() == 0) && message_en;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        vectors++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready @%0t: got %b, expected %b", $time, in_ready, exp_ready);
        end
        vectors++;
        if (out_valid !== (exp_beats.size() > 0)) begin
            errors++;
            $display("FAIL out_valid @%0t: got %b, expected %b", $time, out_valid, exp_beats.size() > 0);
        end
        if (exp_beats.size() > 0) begin
            vectors++;
            if (out_data !== exp_beats[0].d || out_first !== exp_beats[0].f || out_last !== exp_beats[0].l) begin
                errors++;
                $display("FAIL beat @%0t: got data=%h first=%b last=%b, expected data=%h first=%b last=%b",
                         $time, out_data, out_first, out_last, exp_beats[0].d, exp_beats[0].f, exp_beats[0].l);
            end
        end else if (!rst_n) begin
            vectors++;
            if (out_data !== 64'h0 || out_first !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs @%0t: got data=%h first=%b last=%b, expected all 0",
                         $time, out_data, out_first, out_last);
            end
        end
    end

    task automatic start_msg(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                             input logic [187:0] p, output int base);
        int a0;
        bit ok;
        base       = cap.size();
        a0         = acc_total;
        ok         = 1'b0;
        in_type    = t;
        in_op1     = a;
        in_op2     = b;
        in_payload = p;
        in_valid   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_total != a0) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: no acceptance within 20 cycles, expected one");
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (exp_beats.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_beats.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] w;
        int base;
        int s0;
        int d0;
        int c0;

        rst_n      = 1'b0;
        message_en = 1'b1;
        in_valid   = 1'b1;
        in_type    = 4'h1;
        in_op1     = 32'hFFFF_FFFF;
        in_op2     = 32'hFFFF_FFFF;
        in_payload = '1;
        out_ready  = 1'b1;

        // Reset held with in_valid asserted.
        repeat (3) @(negedge clk);
        check_int("rst_in_ready", int'(in_ready), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check64("rst_out_data", out_data, 64'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check_int("release_in_ready", int'(in_ready), 1);

        // Pin the model against hand-computed words.
        w = build_word(4'h1, 32'hA5A5_0001, 32'h1234_5678, '0);
        check64("model_q_beat0", w[255 -: 64], 64'h1A5A_5000_1123_4567);
        check64("model_q_beat1", w[191 -: 64], 64'h8000_0000_0000_0000);
        w = build_word(4'h2, 32'hA5A5_0001, 32'h1234_5678, '0);
        check64("model_nq_beat0", w[255 -: 64], 64'h2A5A_5000_1000_0000);

        // q message, no backpressure.
        start_msg(4'h1, 32'hA5A5_0001, 32'h1234_5678, '0, base);
        drain();
        check_int("q_handshakes", cap.size() - base, NT);
        if (cap.size() - base >= NB) begin
            check64("q_beat0", cap[base],     64'h1A5A_5000_1123_4567);
            check64("q_beat1", cap[base + 1], 64'h8000_0000_0000_0000);
            check64("q_beat2", cap[base + 2], 64'h0);
            check64("q_beat3", cap[base + 3], 64'h0);
`ifdef STAGE5_MSG_CHECKSUM_EN
            if (cap.size() - base >= NT) check64("q_csum", cap[base + 4], 64'h9A5A_5000_1123_4567);
`endif
        end

        // Non-q message: OP2 slot gets the default fill.
        start_msg(4'h2, 32'hA5A5_0001, 32'h1234_5678, '0, base);
        drain();
        check_int("nq_handshakes", cap.size() - base, NT);
        if (cap.size() > base) check64("nq_beat0", cap[base], 64'h2A5A_5000_1000_0000);

        // Backpressure: out_ready low for 3 cycles while beat1 is presented.
        start_msg(4'h1, 32'hA5A5_0001, 32'h1234_5678, '0, base);
        @(negedge clk);
        s0        = stall_total;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        drain();
        check_int("bp_stall_cycles", stall_total - s0, 3);
        check_int("bp_handshakes", cap.size() - base, NT);
        if (cap.size() - base >= 2) check64("bp_beat1", cap[base + 1], 64'h8000_0000_0000_0000);

        // message_en low while idle: no acceptance, no output.
        message_en = 1'b0;
        @(negedge clk);
        d0       = dut_acc;
        c0       = cap.size();
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check_int("en_off_in_ready", int'(in_ready), 0);
        check_int("en_off_accepts", dut_acc - d0, 0);
        check_int("en_off_beats", cap.size() - c0, 0);
        in_valid   = 1'b0;
        message_en = 1'b1;
        @(negedge clk);

        // message_en dropped during beat2: message completes, no new acceptance.
        start_msg(4'hF, 32'hDEAD_BEEF, 32'h0BAD_F00D, {47{4'h9}}, base);
        repeat (2) @(negedge clk);
        message_en = 1'b0;
        drain();
        check_int("en_drop_handshakes", cap.size() - base, NT);
        repeat (3) @(negedge clk);
        check_int("en_drop_in_ready", int'(in_ready), 0);
        message_en = 1'b1;
        @(negedge clk);

        // Reset mid-message discards it; the next message is intact.
        start_msg(4'h1, 32'h0123_4567, 32'h89AB_CDEF, {47{4'h3}}, base);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_int("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        start_msg(4'h3, 32'h1111_2222, 32'h3333_4444, {47{4'hC}}, base);
        drain();
        check_int("post_rst_handshakes", cap.size() - base, NT);
        if (cap.size() > base) check64("post_rst_beat0", cap[base], 64'h3111_1222_2000_0000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stage5_msg_pack.md
Name: stage5_msg_pack

Overview:
- Transmit-side counterpart of the stage-5 field extractors: takes decoded fields (type, OP1, OP2, payload) and assembles one fixed-format message word.
- Serialises the message MSB-first as OUT_WIDTH-bit beats on a valid/ready stream toward the egress link.
- Mirrors the extractor's rule: OP2 is only carried for q-type messages; every other type carries the default fill in the OP2 slot.

Parameters:
- MSG_BITS, 256, message width; equals `MAX_MESSAGE_BITS.
- OUT_WIDTH, 64, beat width; MSG_BITS must be an integer multiple of OUT_WIDTH.
- TYPE_BITS, 4, type field width; equals `message_mux_control_width.
- OP_BITS, 32, width of OP1 and OP2; equals `field_OP2_bits.
- TYPE_Q, 4'h1, type code for a q message; equals `message_mux_q.
- DEFAULT_INFOR, 0, OP2 fill value for non-q messages; equals `defaut_infor.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- message_en, input, 1, block enable; 0 blocks new acceptances.
- in_valid, input, 1, field set valid.
- in_ready, output, 1, field set accepted when in_valid && in_ready.
- in_type, input, TYPE_BITS, message type.
- in_op1, input, OP_BITS, OP1 field.
- in_op2, input, OP_BITS, OP2 field; used only when in_type == TYPE_Q.
- in_payload, input, MSG_BITS-TYPE_BITS-2*OP_BITS, remaining message bits (188 at defaults).
- out_valid, output, 1, beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, OUT_WIDTH, beat data.
- out_first, output, 1, first beat of a message.
- out_last, output, 1, final beat of a message.

Behaviour:
- Message layout, MSB first:
  - [MSB -: TYPE_BITS]: type.
  - Next OP_BITS: OP1.
  - Next OP_BITS: OP2 slot, holding in_op2 if in_type == TYPE_Q, else DEFAULT_INFOR.
  - Remaining bits: payload.
- Reset (rst_n low at a clk edge):
  - State returns to IDLE.
  - in_ready = 0, out_valid = 0, out_first = 0, out_last = 0, out_data = 0.
  - Beat counter = 0; message register cleared.
  - An in-flight message is discarded with no partial completion.
- FSM IDLE:
  - in_ready = message_en.
  - On accept, the assembled word is registered in the cycle of the accept edge. Go to SEND with beat counter = 0.
- FSM SEND:
  - out_valid = 1.
  - out_data = message bits selected by the beat counter (beat 0 = most significant OUT_WIDTH bits).
  - out_first = (cnt == 0); out_last = (cnt == NBEATS-1), where NBEATS = MSG_BITS/OUT_WIDTH.
  - On out_valid && out_ready, cnt increments. On the last beat, go to IDLE, or to CSUM when checksum is enabled.
- Latency: first beat is valid the cycle after input acceptance. With out_ready held high, a message takes NBEATS consecutive cycles.
- Backpressure: while out_ready = 0, out_data, out_first and out_last are held stable; out_valid never drops mid-message.
- in_ready is 0 outside IDLE. Accepting the next message in the last-beat cycle is not supported; the minimum message spacing is NBEATS+1 cycles.
- message_en falling mid-message does not abort: the current message completes and no new message is accepted.
- Type codes other than TYPE_Q are all legal. Only the OP2 slot differs from a q message.

Optional Feature:
- Macro: STAGE5_MSG_CHECKSUM_EN.
- Defined:
  - A trailing CSUM beat follows the last data beat.
  - CSUM beat data = XOR of all NBEATS data beats.
  - During data beats, out_last = 0; during CSUM, out_last = 1 and out_first = 0.
  - CSUM obeys the same backpressure hold rule; it returns to IDLE on handshake.
- Undefined: no CSUM state; the last data beat asserts out_last.

Decomposition:
- Shared constants, not redefined locally:
  - Type codes, including TYPE_Q.
  - DEFAULT_INFOR.
  - Field bit positions (q_OP2_b/q_OP2_e style offsets).
  - MAX_MESSAGE_BITS and field widths.
  - FSM state encodings IDLE/SEND/CSUM.
- One natural sub-module: stage5_msg_assemble, a purely combinational field-to-word packer holding the q/default OP2 mux. The top level keeps the FSM, beat counter and output registers.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 → in_ready = 0, out_valid = 0, all outputs 0; release → in_ready = 1 next cycle (message_en = 1).
- q message, type = 1, op1 = 32'hA5A5_0001, op2 = 32'h1234_5678, payload = 0, out_ready = 1 → 4 beats; beat0 = 64'h1A5A_5000_1123_4567, beat1 = 64'h8000_0000_0000_0000, beats 2–3 = 0; out_first on beat0; out_last on beat3.
- Non-q message, type = 2, same op1/op2 → beat0 = 64'h2A5A_5000_1000_0000; OP2 slot = DEFAULT_INFOR, in_op2 ignored.
- Backpressure: drop out_ready for 3 cycles at beat1 → beat1 data/flags stable for 4 cycles total, no beat skipped or duplicated, 4 handshakes total.
- message_en = 0 in IDLE → in_ready = 0, no output. message_en dropped during beat2 → message finishes and in_ready stays 0.
- Checksum macro defined, the q message above → 5th beat = XOR of beats 0–3 = 64'h9A5A_5000_1123_4567 with out_last = 1; beat3 has out_last = 0.
